light_mode_ctrl: RTL and testbench

- Controller that sequences the 2-bit light state machine.
- Takes raw push-buttons: synchronises, debounces and edge-detects them.
- Drives the light FSM's 2-bit switch input with the selected mode (00 off, 01 level 1, 10 level 2).
- Adds an auto-cycle mode and an inactivity auto-off timer.

---
 rtl/light_mode_ctrl_if.sv | 33 +++
 rtl/light_mode_ctrl.sv | 135 +++++++++++++
 tb/tb_light_mode_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/light_mode_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : light_mode_ctrl_if
//  Purpose  : Button / mode bus between a stimulus source and light_mode_ctrl.
//             Groups the raw buttons, the auto enable and the mode outputs.
//  Revision : 1.0  initial release
// ============================================================================
interface light_mode_ctrl_if;
    logic       i_btn_next;
    logic       i_btn_off;
    logic       i_auto_en;
    logic [1:0] o_OnOffSW;
    logic       o_btn_accept;

    // Source side: drives the buttons, observes the selected mode
    modport master (
        output i_btn_next,
        output i_btn_off,
        output i_auto_en,
        input  o_OnOffSW,
        input  o_btn_accept
    );

    // Controller side
    modport slave (
        input  i_btn_next,
        input  i_btn_off,
        input  i_auto_en,
        output o_OnOffSW,
        output o_btn_accept
    );
endinterface
`default_nettype wire

// File: rtl/light_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : light_mode_ctrl
//  Purpose  : Mode sequencer for the 2-bit light FSM. Synchronises, debounces
//             and edge-detects two raw push-buttons, then steps OFF/L1/L2 with
//             an optional auto-cycle between L1/L2 and an inactivity auto-off.
//  Revision : 1.0  initial release
// ============================================================================
module light_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES  = 4,
    parameter int AUTO_OFF_CYCLES  = 64,
    parameter int AUTO_STEP_CYCLES = 16
) (
    input  wire logic         i_clk,
    input  wire logic         i_reset,
    light_mode_ctrl_if.slave  bus
);

    localparam int c_DEB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int c_IDLE_W = $clog2(AUTO_OFF_CYCLES);
    localparam int c_STEP_W = $clog2(AUTO_STEP_CYCLES);

    localparam logic [c_DEB_W-1:0]  c_DEB_LAST  = c_DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(AUTO_OFF_CYCLES - 1);
    localparam logic [c_STEP_W-1:0] c_STEP_LAST = c_STEP_W'(AUTO_STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_OFF = 2'b00,
        S_L1  = 2'b01,
        S_L2  = 2'b10
    } state_t;

    // Bit 0 = "next" button, bit 1 = "off" button
    logic [1:0] w_raw;
    logic [1:0] w_pulse;

    assign w_raw = {bus.i_btn_off, bus.i_btn_next};

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic               s1_q;
        logic               s2_q;
        logic               deb_q;
        logic               deb_prev_q;
        logic [c_DEB_W-1:0] cnt_q;

        // Synchronise, then accept a level only after DEBOUNCE_CYCLES agreeing samples
        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                s1_q       <= 1'b0;
                s2_q       <= 1'b0;
                deb_q      <= 1'b0;
                deb_prev_q <= 1'b0;
                cnt_q      <= '0;
            end else begin
                s1_q       <= w_raw[gi];
                s2_q       <= s1_q;
                deb_prev_q <= deb_q;
                if (s2_q != deb_q) begin
                    if (cnt_q == c_DEB_LAST) begin
                        deb_q <= s2_q;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end else begin
                    cnt_q <= '0;
                end
            end
        end

        // Press edge only; releases are ignored
        assign w_pulse[gi] = deb_q & ~deb_prev_q;
    end

    state_t                state_q, state_d;
    logic [c_IDLE_W-1:0]   idle_q,  idle_d;
    logic [c_STEP_W-1:0]   step_q,  step_d;
    logic                  accept_q;
    logic                  w_on;
    logic                  w_step_hit;
    logic                  w_idle_hit;
    logic                  w_change;

    assign w_on       = (state_q == S_L1) || (state_q == S_L2);
    assign w_step_hit = w_on &&  bus.i_auto_en && (step_q == c_STEP_LAST);
    assign w_idle_hit = w_on && !bus.i_auto_en && (idle_q == c_IDLE_LAST);

    // Next mode: off button beats next button beats auto-step beats auto-off
    always_comb begin
        state_d = state_q;
        if (w_pulse[1]) begin
            state_d = S_OFF;
        end else if (w_pulse[0]) begin
            case (state_q)
                S_OFF:   state_d = S_L1;
                S_L1:    state_d = S_L2;
                default: state_d = S_OFF;
            endcase
        end else if (w_step_hit) begin
            state_d = (state_q == S_L1) ? S_L2 : S_L1;
        end else if (w_idle_hit) begin
            state_d = S_OFF;
        end else if (!w_on) begin
            // Keeps S_OFF and pulls the unused 11 encoding back to off
            state_d = S_OFF;
        end
    end

    // Timers restart on every mode change; each only runs in its own auto setting
    always_comb begin
        w_change = (state_d != state_q);
        idle_d   = (!w_on || w_change ||  bus.i_auto_en) ? '0 : idle_q + 1'b1;
        step_d   = (!w_on || w_change || !bus.i_auto_en) ? '0 : step_q + 1'b1;
    end

    // Mode, timers and the one-cycle accept flag
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= S_OFF;
            idle_q   <= '0;
            step_q   <= '0;
            accept_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idle_q   <= idle_d;
            step_q   <= step_d;
            accept_q <= w_change;
        end
    end

    assign bus.o_OnOffSW    = state_q;
    assign bus.o_btn_accept = accept_q;

endmodule
`default_nettype wire

// File: tb/tb_light_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_light_mode_ctrl
//  Purpose  : Self-checking bench for light_mode_ctrl: table of directed
//             vectors, hand sequences for latency/reset corners, and random
//             stimulus against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_light_mode_ctrl;

    localparam int DEB   = 4;
    localparam int AOFF  = 64;
    localparam int ASTEP = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    light_mode_ctrl_if bus_if ();

    light_mode_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .AUTO_OFF_CYCLES (AOFF),
        .AUTO_STEP_CYCLES(ASTEP)
    ) u_dut (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (bus_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       nx;
        logic       of;
        logic       au;
        int         cycles;
        logic [1:0] exp_sw;
        logic       exp_acc;
    } vec_t;

    vec_t tbl[$];

    // ---------------- behavioural model state ----------------
    logic [1:0] raw_log[$];   // raw buttons as they move through the 2-stage sync
    logic [1:0] s_log[$];     // last DEB synchronised samples
    logic [1:0] m_deb, m_prev;
    int         m_mode;       // 0 off, 1 level 1, 2 level 2
    logic       m_acc;
    int         m_idle_age, m_step_age;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic nx, input logic of, input logic au);
        bus_if.i_btn_next = nx;
        bus_if.i_btn_off  = of;
        bus_if.i_auto_en  = au;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("reset_sw",  32'(bus_if.o_OnOffSW),    32'd0);
        check("reset_acc", 32'(bus_if.o_btn_accept), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic press(input int hold, input int rel);
        drive(1'b1, 1'b0, 1'b0);
        cyc(hold);
        drive(1'b0, 1'b0, 1'b0);
        cyc(rel);
    endtask

    task automatic model_init();
        raw_log.delete();
        raw_log.push_back(2'b00);
        raw_log.push_back(2'b00);
        s_log.delete();
        m_deb      = 2'b00;
        m_prev     = 2'b00;
        m_mode     = 0;
        m_acc      = 1'b0;
        m_idle_age = 0;
        m_step_age = 0;
    endtask

    // One clock edge of the model; raw[0] = next, raw[1] = off
    task automatic model_edge(input logic [1:0] raw, input logic au);
        logic [1:0] synced;
        logic [1:0] press_now;
        int         nm;
        logic       all_diff;
        synced = raw_log.pop_front();
        raw_log.push_back(raw);
        press_now = m_deb & ~m_prev;

        nm = m_mode;
        if (press_now[1])                                         nm = 0;
        else if (press_now[0])                                    nm = (m_mode + 1) % 3;
        else if (m_mode != 0 &&  au && m_step_age == ASTEP - 1)   nm = 3 - m_mode;
        else if (m_mode != 0 && !au && m_idle_age == AOFF - 1)    nm = 0;

        m_acc      = (nm != m_mode);
        m_idle_age = (nm == 0 || m_acc ||  au) ? 0 : m_idle_age + 1;
        m_step_age = (nm == 0 || m_acc || !au) ? 0 : m_step_age + 1;
        m_mode     = nm;

        m_prev = m_deb;
        s_log.push_back(synced);
        if (s_log.size() > DEB) void'(s_log.pop_front());
        for (int b = 0; b < 2; b++) begin
            if (s_log.size() == DEB) begin
                all_diff = 1'b1;
                foreach (s_log[k]) if (s_log[k][b] == m_deb[b]) all_diff = 1'b0;
                if (all_diff) m_deb[b] = ~m_deb[b];
            end
        end
    endtask

    initial begin
        int  run_nx, run_of, run_au;
        logic lv_nx, lv_of, lv_au;

        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        cyc(2);
        check("por_sw",  32'(bus_if.o_OnOffSW),    32'd0);
        check("por_acc", 32'(bus_if.o_btn_accept), 32'd0);
        rst = 1'b0;

        // ---- held press: first change at edge DEB+3, accept exactly one cycle ----
        drive(1'b1, 1'b0, 1'b0);
        for (int e = 1; e <= 20; e++) begin
            cyc(1);
            check("hold_sw",  32'(bus_if.o_OnOffSW),    (e >= DEB + 3) ? 32'd1 : 32'd0);
            check("hold_acc", 32'(bus_if.o_btn_accept), (e == DEB + 3) ? 32'd1 : 32'd0);
        end
        drive(1'b0, 1'b0, 1'b0);
        cyc(10);

        // ---- bounce shorter than the debounce window is ignored ----
        do_reset();
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                drive(c < 3, 1'b0, 1'b0);
                cyc(1);
                check("glitch_sw",  32'(bus_if.o_OnOffSW),    32'd0);
                check("glitch_acc", 32'(bus_if.o_btn_accept), 32'd0);
            end
        end
        drive(1'b0, 1'b0, 1'b0);
        cyc(10);
        check("glitch_end_sw", 32'(bus_if.o_OnOffSW), 32'd0);

        // ---- table: clean presses cycle 00 -> 01 -> 10 -> 00 -> 01 ----
        do_reset();
        tbl.push_back('{1'b1, 1'b0, 1'b0, 6,  2'b00, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1,  2'b01, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1,  2'b01, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 2,  2'b01, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 10, 2'b01, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 7,  2'b10, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 3,  2'b10, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 10, 2'b10, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 7,  2'b00, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 3,  2'b00, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 10, 2'b00, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 7,  2'b01, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 3,  2'b01, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 4,  2'b01, 1'b0});
        foreach (tbl[i]) begin
            drive(tbl[i].nx, tbl[i].of, tbl[i].au);
            cyc(tbl[i].cycles);
            check($sformatf("tbl%0d_sw", i),  32'(bus_if.o_OnOffSW),    32'(tbl[i].exp_sw));
            check($sformatf("tbl%0d_acc", i), 32'(bus_if.o_btn_accept), 32'(tbl[i].exp_acc));
        end

        // ---- auto-cycle from L1, then auto-off after AOFF idle edges ----
        drive(1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 50; k++) begin
            cyc(1);
            check("auto_sw",  32'(bus_if.o_OnOffSW),    ((k / ASTEP) % 2 == 0) ? 32'd1 : 32'd2);
            check("auto_acc", 32'(bus_if.o_btn_accept), (k % ASTEP == 0) ? 32'd1 : 32'd0);
        end
        drive(1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 70; k++) begin
            cyc(1);
            check("aoff_sw",  32'(bus_if.o_OnOffSW),    (k < AOFF) ? 32'd2 : 32'd0);
            check("aoff_acc", 32'(bus_if.o_btn_accept), (k == AOFF) ? 32'd1 : 32'd0);
        end

        // ---- simultaneous next + off in L2: off wins ----
        do_reset();
        press(10, 10);
        press(10, 10);
        check("both_pre_sw", 32'(bus_if.o_OnOffSW), 32'd2);
        drive(1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            cyc(1);
            check("both_sw",  32'(bus_if.o_OnOffSW),    (k < DEB + 3) ? 32'd2 : 32'd0);
            check("both_acc", 32'(bus_if.o_btn_accept), (k == DEB + 3) ? 32'd1 : 32'd0);
        end
        drive(1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            cyc(1);
            check("both_after_sw", 32'(bus_if.o_OnOffSW), 32'd0);
        end

        // ---- async reset mid-debounce in L2, button still held afterwards ----
        do_reset();
        press(10, 10);
        press(10, 10);
        check("rstmid_pre_sw", 32'(bus_if.o_OnOffSW), 32'd2);
        drive(1'b1, 1'b0, 1'b0);
        cyc(3);
        #2 rst = 1'b1;
        #1;
        check("rstmid_async_sw",  32'(bus_if.o_OnOffSW),    32'd0);
        check("rstmid_async_acc", 32'(bus_if.o_btn_accept), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            cyc(1);
            check("rstmid_sw",  32'(bus_if.o_OnOffSW),    (k >= DEB + 3) ? 32'd1 : 32'd0);
            check("rstmid_acc", 32'(bus_if.o_btn_accept), (k == DEB + 3) ? 32'd1 : 32'd0);
        end

        // ---- random stimulus against the model ----
        do_reset();
        model_init();
        run_nx = 0; run_of = 0; run_au = 0;
        lv_nx = 1'b0; lv_of = 1'b0; lv_au = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if (run_nx == 0) begin
                lv_nx  = ($urandom_range(1, 0) == 1);
                run_nx = ($urandom_range(3, 0) == 0) ? $urandom_range(3, 1) : $urandom_range(40, 6);
            end
            if (run_of == 0) begin
                lv_of  = ($urandom_range(5, 0) == 0);
                run_of = ($urandom_range(3, 0) == 0) ? $urandom_range(3, 1) : $urandom_range(40, 6);
            end
            if (run_au == 0) begin
                lv_au  = ($urandom_range(1, 0) == 1);
                run_au = $urandom_range(300, 30);
            end
            run_nx--; run_of--; run_au--;
            drive(lv_nx, lv_of, lv_au);
            model_edge({lv_of, lv_nx}, lv_au);
            cyc(1);
            check("rnd_sw",  32'(bus_if.o_OnOffSW),    32'(m_mode));
            check("rnd_acc", 32'(bus_if.o_btn_accept), 32'(m_acc));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
